// File: rtl/stream_unpacker_pkg.sv
// rtl/stream_unpacker_pkg.sv - state type and sizing helpers for the stream unpacker
`include "stream_unpacker_defs.vh"

package stream_unpacker_pkg;

    typedef enum logic {
        S_EMPTY = `ST_EMPTY,
        S_HOLD  = `ST_HOLD
    } state_e;

    localparam int DEFAULT_COUNT_WIDTH = `STREAM_UNPACKER_COUNT_WIDTH;

    // A one-beat ratio still needs a 1-bit index so the counter has a real port.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/stream_unpacker_beat_ctr.sv
// rtl/stream_unpacker_beat_ctr.sv - modulo-RATIO beat index with clear/load/advance
module stream_unpacker_beat_ctr #(
    parameter int RATIO = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             advance,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    assign idx  = idx_q;
    assign last = (idx_q == IDX_W'(RATIO - 1));

    always_comb begin
        idx_d = idx_q;
        if (clear || load) begin
            idx_d = '0;
        end else if (advance) begin
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/stream_unpacker_defs.vh
// rtl/stream_unpacker_defs.vh - shared state encodings, ratio macro and default counter width
`ifndef STREAM_UNPACKER_DEFS_VH
`define STREAM_UNPACKER_DEFS_VH

`define ST_EMPTY 1'b0
`define ST_HOLD  1'b1
`define RATIO(in, out) ((in) / (out))
`define STREAM_UNPACKER_COUNT_WIDTH 8

`endif

// File: rtl/stream_unpacker.sv
// rtl/stream_unpacker.sv - splits each WIDTH_IN word into WIDTH_IN/WIDTH_OUT output beats
`include "stream_unpacker_defs.vh"

module stream_unpacker
    import stream_unpacker_pkg::*;
#(
    parameter int WIDTH_IN    = 8,
    parameter int WIDTH_OUT   = 4,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH_IN-1:0]    in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH_OUT-1:0]   out_data,
    output logic                   out_first,
    output logic                   out_last,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] word_count
);

    localparam int RATIO = `RATIO(WIDTH_IN, WIDTH_OUT);
    localparam int IDX_W = idx_width(RATIO);

    generate
        if (WIDTH_OUT < 1) begin : g_bad_out
            $error("stream_unpacker: WIDTH_OUT must be at least 1");
        end
        if ((WIDTH_IN % WIDTH_OUT) != 0) begin : g_bad_ratio
            $error("stream_unpacker: WIDTH_IN must be a multiple of WIDTH_OUT");
        end
    endgenerate

    state_e                 state_q, state_d;
    logic [WIDTH_IN-1:0]    word_q, word_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [IDX_W-1:0]       idx;
    logic                   idx_last;
    logic                   ctr_clear, ctr_load, ctr_advance;
    logic                   in_hs, out_hs;
    logic [IDX_W-1:0]       sel;
    logic [WIDTH_IN-1:0]    shifted;

    stream_unpacker_beat_ctr #(
        .RATIO (RATIO),
        .IDX_W (IDX_W)
    ) u_beat_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (ctr_clear),
        .load    (ctr_load),
        .advance (ctr_advance),
        .idx     (idx),
        .last    (idx_last)
    );

    assign out_valid  = (state_q == S_HOLD);
    assign out_first  = out_valid && (idx == '0);
    assign out_last   = out_valid && idx_last;
    assign word_count = count_q;

    // Refilling on the last beat's handshake keeps back-to-back words bubble-free.
    assign in_ready = !flush && ((state_q == S_EMPTY) || (out_last && out_ready));
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    assign sel      = LSB_FIRST ? idx : IDX_W'(RATIO - 1) - idx;
    assign shifted  = word_q >> (32'(sel) * WIDTH_OUT);
    assign out_data = shifted[WIDTH_OUT-1:0];

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        count_d     = count_q;
        ctr_clear   = 1'b0;
        ctr_load    = 1'b0;
        ctr_advance = 1'b0;
        if (flush && (state_q == S_HOLD)) begin
            state_d   = S_EMPTY;
            ctr_clear = 1'b1;
        end else if (in_hs) begin
            state_d  = S_HOLD;
            word_d   = in_data;
            ctr_load = 1'b1;
            if (out_hs && idx_last) begin
                count_d = count_q + 1'b1;
            end
        end else if (out_hs) begin
            if (idx_last) begin
                state_d   = S_EMPTY;
                count_d   = count_q + 1'b1;
                ctr_clear = 1'b1;
            end else begin
                ctr_advance = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            word_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_stream_unpacker.sv
// tb/tb_stream_unpacker.sv - directed self-checking bench for the stream unpacker
module tb_stream_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready, out_first, out_last, flush;
    logic [7:0] in_data, word_count;
    logic [3:0] out_data;

    logic        b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_out_first, b_out_last, b_flush;
    logic [11:0] b_in_data;
    logic [3:0]  b_out_data;
    logic [1:0]  b_word_count;

    int compared = 0;
    int mismatched = 0;

    stream_unpacker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_first(out_first), .out_last(out_last),
        .flush(flush), .word_count(word_count)
    );

    stream_unpacker #(.WIDTH_IN(12), .WIDTH_OUT(4), .LSB_FIRST(1'b0), .COUNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_first(b_out_first), .out_last(b_out_last),
        .flush(b_flush), .word_count(b_word_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
        step(); step();
        reset = 1'b0; b_reset = 1'b0;
        #1;
        compared++;
        if ({out_valid, out_data, out_first, out_last, word_count} !== 15'h0) begin
            mismatched++;
            $display("FAIL reset_state: v=%b d=%h f=%b l=%b cnt=%0d, required all zero",
                     out_valid, out_data, out_first, out_last, word_count);
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        compared++;
        if ({out_valid, out_data, out_first, out_last} !== {1'b1, 4'h5, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL single_beat0: v=%b d=%h f=%b l=%b required v=1 d=5 f=1 l=0",
                     out_valid, out_data, out_first, out_last);
        end
        step();
        compared++;
        if ({out_valid, out_data, out_first, out_last} !== {1'b1, 4'hA, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL single_beat1: v=%b d=%h f=%b l=%b required v=1 d=a f=0 l=1",
                     out_valid, out_data, out_first, out_last);
        end
        step();
        compared++;
        if ({out_valid, word_count} !== {1'b0, 8'd1}) begin
            mismatched++;
            $display("FAIL single_done: v=%b cnt=%0d required v=0 cnt=1", out_valid, word_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_beat [4];
        logic       exp_rdy  [4];
        exp_beat = '{4'h2, 4'h1, 4'h4, 4'h3};
        exp_rdy  = '{1'b0, 1'b1, 1'b0, 1'b1};
        in_valid = 1'b1; in_data = 8'h12; out_ready = 1'b1;
        step();
        in_data = 8'h34;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if ({out_valid, out_data, in_ready} !== {1'b1, exp_beat[i], exp_rdy[i]}) begin
                mismatched++;
                $display("FAIL b2b_beat%0d: v=%b d=%h in_ready=%b required v=1 d=%h in_ready=%b",
                         i, out_valid, out_data, in_ready, exp_beat[i], exp_rdy[i]);
            end
            step();
            if (i == 1) in_valid = 1'b0;
        end
        compared++;
        if ({out_valid, word_count} !== {1'b0, 8'd3}) begin
            mismatched++;
            $display("FAIL b2b_done: v=%b cnt=%0d required v=0 cnt=3", out_valid, word_count);
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if ({out_valid, out_data, in_ready} !== {1'b1, 4'h5, 1'b0}) begin
                mismatched++;
                $display("FAIL bp_stall%0d: v=%b d=%h in_ready=%b required v=1 d=5 in_ready=0",
                         i, out_valid, out_data, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        compared++;
        if ({out_valid, out_data, out_first} !== {1'b1, 4'h5, 1'b1}) begin
            mismatched++;
            $display("FAIL bp_beat0: v=%b d=%h f=%b required v=1 d=5 f=1", out_valid, out_data, out_first);
        end
        step();
        compared++;
        if ({out_valid, out_data, out_last} !== {1'b1, 4'hA, 1'b1}) begin
            mismatched++;
            $display("FAIL bp_beat1: v=%b d=%h l=%b required v=1 d=a l=1", out_valid, out_data, out_last);
        end
        step();
        compared++;
        if ({out_valid, word_count} !== {1'b0, 8'd4}) begin
            mismatched++;
            $display("FAIL bp_done: v=%b cnt=%0d required v=0 cnt=4", out_valid, word_count);
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = 8'hC3; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        in_valid = 1'b1; in_data = 8'h99;
        #1;
        compared++;
        if ({out_valid, out_data, out_last, in_ready} !== {1'b1, 4'hC, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL flush_pending: v=%b d=%h l=%b in_ready=%b required v=1 d=c l=1 in_ready=0",
                     out_valid, out_data, out_last, in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0;
        compared++;
        if ({out_valid, word_count} !== {1'b0, 8'd4}) begin
            mismatched++;
            $display("FAIL flush_after: v=%b cnt=%0d required v=0 cnt=4", out_valid, word_count);
        end
        in_valid = 1'b1; in_data = 8'h7E;
        step();
        in_valid = 1'b0;
        compared++;
        if ({out_valid, out_data, out_first} !== {1'b1, 4'hE, 1'b1}) begin
            mismatched++;
            $display("FAIL flush_next0: v=%b d=%h f=%b required v=1 d=e f=1", out_valid, out_data, out_first);
        end
        step();
        compared++;
        if ({out_valid, out_data, out_last} !== {1'b1, 4'h7, 1'b1}) begin
            mismatched++;
            $display("FAIL flush_next1: v=%b d=%h l=%b required v=1 d=7 l=1", out_valid, out_data, out_last);
        end
        step();
        compared++;
        if (word_count !== 8'd5) begin
            mismatched++;
            $display("FAIL flush_count: cnt=%0d required 5", word_count);
        end
    endtask

    task automatic test_reset_mid_word();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        compared++;
        if ({out_valid, out_data, word_count} !== 13'h0) begin
            mismatched++;
            $display("FAIL rst_mid: v=%b d=%h cnt=%0d required all zero", out_valid, out_data, word_count);
        end
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        compared++;
        if ({out_valid, out_data, out_first} !== {1'b1, 4'hA, 1'b1}) begin
            mismatched++;
            $display("FAIL rst_next0: v=%b d=%h f=%b required v=1 d=a f=1", out_valid, out_data, out_first);
        end
        step();
        compared++;
        if ({out_valid, out_data, out_last} !== {1'b1, 4'h5, 1'b1}) begin
            mismatched++;
            $display("FAIL rst_next1: v=%b d=%h l=%b required v=1 d=5 l=1", out_valid, out_data, out_last);
        end
        step();
        compared++;
        if ({out_valid, word_count} !== {1'b0, 8'd1}) begin
            mismatched++;
            $display("FAIL rst_count: v=%b cnt=%0d required v=0 cnt=1", out_valid, word_count);
        end
    endtask

    task automatic test_override();
        logic [3:0] exp_beat [3];
        logic [1:0] exp_cnt  [5];
        exp_beat = '{4'hA, 4'hB, 4'hC};
        exp_cnt  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        b_out_ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            b_in_valid = 1'b1; b_in_data = 12'hABC;
            step();
            b_in_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                compared++;
                if ({b_out_valid, b_out_data, b_out_first, b_out_last} !==
                    {1'b1, exp_beat[k], (k == 0), (k == 2)}) begin
                    mismatched++;
                    $display("FAIL ovr_w%0d_b%0d: v=%b d=%h f=%b l=%b required v=1 d=%h f=%b l=%b",
                             w, k, b_out_valid, b_out_data, b_out_first, b_out_last,
                             exp_beat[k], (k == 0), (k == 2));
                end
                step();
            end
            compared++;
            if ({b_out_valid, b_word_count} !== {1'b0, exp_cnt[w]}) begin
                mismatched++;
                $display("FAIL ovr_count%0d: v=%b cnt=%0d required v=0 cnt=%0d",
                         w, b_out_valid, b_word_count, exp_cnt[w]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_word();
        test_override();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
